// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions: g..a segment patterns (0 = lit) and special display codes.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_UNDER = 7'b1110111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [4:0] CODE_MINUS = 5'h11;
  localparam logic [4:0] CODE_UNDER = 5'h12;
  localparam logic [4:0] CODE_BLANK = 5'h1F;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational inverse of the hex-to-7-segment encoder: g..a pattern -> display code.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [4:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_BLANK;
    err  = 1'b0;
    case (seg)
      SEG_0:     code = 5'h00;
      SEG_1:     code = 5'h01;
      SEG_2:     code = 5'h02;
      SEG_3:     code = 5'h03;
      SEG_4:     code = 5'h04;
      SEG_5:     code = 5'h05;
      SEG_6:     code = 5'h06;
      SEG_7:     code = 5'h07;
      SEG_8:     code = 5'h08;
      SEG_9:     code = 5'h09;
      SEG_A:     code = 5'h0A;
      SEG_B:     code = 5'h0B;
      SEG_C:     code = 5'h0C;
      SEG_D:     code = 5'h0D;
      SEG_E:     code = 5'h0E;
      SEG_F:     code = 5'h0F;
      SEG_MINUS: code = CODE_MINUS;
      SEG_UNDER: code = CODE_UNDER;
      SEG_BLANK: code = CODE_BLANK;
      default:   err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Samples a multiplexed active-low 7-segment bus, accepts each digit pattern once after a
// stability window, and stores the decoded code/dp/err per digit slot with a frame pulse.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [5*DIGITS-1:0]   code_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  frame_valid
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  logic [7:0]                  s_seg_q, s_seg_d;
  logic [DIGITS-1:0]           s_dig_q, s_dig_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        acc_q, acc_d;
  logic [DIGITS-1:0]           upd_q, upd_d;
  logic [DIGITS-1:0][4:0]      code_q, code_d;
  logic [DIGITS-1:0]           dp_q, dp_d;
  logic [DIGITS-1:0]           err_q, err_d;
  logic                        fv_q, fv_d;

  logic [4:0]                  dec_code;
  logic                        dec_err;
  logic                        s_onehot;
  logic [IDX_W-1:0]            s_idx;
  logic                        same;
  logic                        accept;

  sevenseg_decode u_decode (
    .seg  (s_seg_q[7:1]),
    .code (dec_code),
    .err  (dec_err)
  );

  always_comb begin
    s_onehot = $onehot(s_dig_q);
    s_idx    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (s_dig_q[i]) s_idx = IDX_W'(i);
    end
  end

  always_comb begin
    s_seg_d = seg_in;
    s_dig_d = dig_sel;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    upd_d   = upd_q;
    code_d  = code_q;
    dp_d    = dp_q;
    err_d   = err_q;
    fv_d    = 1'b0;

    same   = ({seg_in, dig_sel} == {s_seg_q, s_dig_q});
    accept = s_onehot && (cnt_q == CNT_MAX) && !acc_q;

    if (accept) begin
      code_d[s_idx] = dec_code;
      dp_d[s_idx]   = ~s_seg_q[0];
      err_d[s_idx]  = dec_err;
      acc_d         = 1'b1;
      upd_d[s_idx]  = 1'b1;
      if (&upd_d) begin
        fv_d  = 1'b1;
        upd_d = '0;
      end
    end

    // A changing sample clears the accepted flag even on an accept edge: the new
    // pattern must earn its own full dwell.
    if (!same) acc_d = 1'b0;

    if (!$onehot(dig_sel) || !same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q <= '0;
      s_dig_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      upd_q   <= '0;
      code_q  <= '1;
      dp_q    <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      s_seg_q <= s_seg_d;
      s_dig_q <= s_dig_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      upd_q   <= upd_d;
      code_q  <= code_d;
      dp_q    <= dp_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  assign code_out    = code_q;
  assign dp_out      = dp_q;
  assign err_out     = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboard bench for sevenseg_capture: stimulus pushes expected output snapshots, a
// negedge monitor pops one whenever the outputs change or frame_valid pulses.
module tb_sevenseg_capture;

  localparam int unsigned DIGITS     = 4;
  localparam int unsigned STABLE_CYC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  dig_sel = 4'b0000;
  logic [19:0] code_out;
  logic [3:0]  dp_out;
  logic [3:0]  err_out;
  logic        frame_valid;

  always #5 clk = ~clk;

  sevenseg_capture #(
    .DIGITS     (DIGITS),
    .STABLE_CYC (STABLE_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .code_out    (code_out),
    .dp_out      (dp_out),
    .err_out     (err_out),
    .frame_valid (frame_valid)
  );

  typedef struct {
    logic [19:0] code;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        fv;
    int          cyc;
  } ev_t;

  ev_t q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic [19:0] m_code = 20'hFFFFF;
  logic [3:0]  m_dp   = 4'h0;
  logic [3:0]  m_err  = 4'h0;
  logic [3:0]  m_upd  = 4'h0;

  logic [19:0] p_code;
  logic [3:0]  p_dp, p_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_write(input int slot, input logic [4:0] code, input logic dp,
                              input logic err);
    ev_t e;
    m_code[slot*5 +: 5] = code;
    m_dp[slot]  = dp;
    m_err[slot] = err;
    m_upd[slot] = 1'b1;
    e.fv = 1'b0;
    if (&m_upd) begin
      e.fv  = 1'b1;
      m_upd = 4'h0;
    end
    e.code = m_code;
    e.dp   = m_dp;
    e.err  = m_err;
    e.cyc  = cyc + STABLE_CYC + 1;
    q.push_back(e);
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
    seg_in  = s;
    dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic acc(input int slot, input logic [7:0] s, input logic [4:0] code,
                     input logic err, input int n);
    expect_write(slot, code, ~s[0], err);
    hold(s, 4'(1 << slot), n);
  endtask

  task automatic do_reset();
    ev_t e;
    m_code = 20'hFFFFF;
    m_dp   = 4'h0;
    m_err  = 4'h0;
    m_upd  = 4'h0;
    e.code = m_code;
    e.dp   = m_dp;
    e.err  = m_err;
    e.fv   = 1'b0;
    e.cyc  = cyc + 1;
    q.push_back(e);
    rst     = 1'b1;
    seg_in  = 8'hFF;
    dig_sel = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (code_out !== p_code || dp_out !== p_dp || err_out !== p_err || frame_valid !== 1'b0) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update: code=%h dp=%b err=%b fv=%b, expected no change (cycle %0d)",
                   code_out, dp_out, err_out, frame_valid, cyc);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("code_out", 32'(code_out), 32'(e.code));
          check("dp_out", 32'(dp_out), 32'(e.dp));
          check("err_out", 32'(err_out), 32'(e.err));
          check("frame_valid", 32'(frame_valid), 32'(e.fv));
          check("update_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (q.size() > 0 && cyc >= q[0].cyc) begin
        ev_t m;
        m = q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_update: no output change, expected code=%h dp=%b err=%b fv=%b at cycle %0d",
                 m.code, m.dp, m.err, m.fv, m.cyc);
      end
      p_code = code_out;
      p_dp   = dp_out;
      p_err  = err_out;
    end
  end

  initial begin
    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_code", 32'(code_out), 32'h000FFFFF);
    check("rst_dp", 32'(dp_out), 32'h0);
    check("rst_err", 32'(err_out), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    p_code = code_out;
    p_dp   = dp_out;
    p_err  = err_out;
    mon_en = 1'b1;

    // 2: long dwell on digit 0 gives a single write
    acc(0, 8'h81, 5'h00, 1'b0, 12);
    hold(8'hFF, 4'b0000, 3);

    // 3: full scan, frame on the fourth write
    acc(0, 8'hF3, 5'h01, 1'b0, 6);
    acc(1, 8'h49, 5'h02, 1'b0, 6);
    acc(2, 8'h61, 5'h03, 1'b0, 6);
    acc(3, 8'h33, 5'h04, 1'b0, 6);
    hold(8'hFF, 4'b0000, 3);

    // 4a: pattern changes before the window closes
    hold(8'h81, 4'b0010, 2);
    hold(8'h49, 4'b0010, 3);
    hold(8'hFF, 4'b0000, 4);
    // 4b: ghosted select never accepted
    hold(8'h81, 4'b0011, 10);
    hold(8'hFF, 4'b0000, 3);

    // 5: special patterns on slot 0
    acc(0, 8'h7F, 5'h11, 1'b0, 6);
    acc(0, 8'hEF, 5'h12, 1'b0, 6);
    acc(0, 8'h00, 5'h08, 1'b0, 6);
    acc(0, 8'hFF, 5'h1F, 1'b0, 6);
    acc(0, 8'h5B, 5'h1F, 1'b1, 6);
    hold(8'hFF, 4'b0000, 3);

    // 6: partial frame discarded by reset
    acc(0, 8'h81, 5'h00, 1'b0, 6);
    acc(1, 8'hF3, 5'h01, 1'b0, 6);
    do_reset();
    acc(0, 8'hF3, 5'h01, 1'b0, 6);
    acc(1, 8'h49, 5'h02, 1'b0, 6);
    acc(2, 8'h61, 5'h03, 1'b0, 6);
    acc(3, 8'h33, 5'h04, 1'b0, 6);
    hold(8'hFF, 4'b0000, 10);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
